// File: rtl/usb_token_decoder.sv
// USB token packet decoder: takes NRZI-decoded, unstuffed bits after SYNC and checks the PID and CRC5.
// When a token is good it loads the PID, address and endpoint. Any other packet gives one error pulse.
module usb_token_decoder (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sync_detected,
  input  logic       bit_valid,
  input  logic       d_bit,
  input  logic       eop,
  output logic [3:0] rx_pid,
  output logic [6:0] rx_addr,
  output logic [3:0] rx_endp,
  output logic       token_valid,
  output logic       token_error,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StRxPid, StRxBody, StWaitEop, StIgnore} state_e;

  localparam logic [4:0] CrcPreset   = 5'b11111;
  localparam logic [4:0] CrcPoly     = 5'b00101;
  localparam logic [4:0] CrcResidual = 5'b01100;

  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  pid_sr_q;
  logic [10:0] body_sr_q;
  logic [4:0]  crc_q;

  logic [7:0]  pid_next;
  logic [4:0]  crc_next;
  logic        pid_ok;

  always_comb begin
    pid_next = {d_bit, pid_sr_q[7:1]};
    crc_next = {crc_q[3:0], 1'b0} ^ ((crc_q[4] ^ d_bit) ? CrcPoly : 5'b00000);
    pid_ok   = (pid_next[7:4] == ~pid_next[3:0]) &&
               ((pid_next[3:0] == 4'b0001) || (pid_next[3:0] == 4'b1001) ||
                (pid_next[3:0] == 4'b1101));
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      pid_sr_q    <= 8'd0;
      body_sr_q   <= 11'd0;
      crc_q       <= CrcPreset;
      rx_pid      <= 4'd0;
      rx_addr     <= 7'd0;
      rx_endp     <= 4'd0;
      token_valid <= 1'b0;
      token_error <= 1'b0;
    end else begin
      token_valid <= 1'b0;
      token_error <= 1'b0;
      // A new SYNC silently abandons whatever packet was in progress.
      if (sync_detected) begin
        state_q   <= StRxPid;
        bit_cnt_q <= 4'd0;
        crc_q     <= CrcPreset;
      end else begin
        unique case (state_q)
          StIdle: ;
          StRxPid: begin
            if (eop) begin
              token_error <= 1'b1;
              state_q     <= StIdle;
            end else if (bit_valid) begin
              pid_sr_q <= pid_next;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                state_q   <= pid_ok ? StRxBody : StIgnore;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StRxBody: begin
            if (eop) begin
              token_error <= 1'b1;
              state_q     <= StIdle;
            end else if (bit_valid) begin
              crc_q <= crc_next;
              // Only addr and endp are kept; the CRC bits are checked through crc_q.
              if (bit_cnt_q < 4'd11) body_sr_q[bit_cnt_q] <= d_bit;
              if (bit_cnt_q == 4'd15) begin
                bit_cnt_q <= 4'd0;
                state_q   <= StWaitEop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StWaitEop: begin
            if (eop) begin
              if (crc_q == CrcResidual) begin
                token_valid <= 1'b1;
                rx_pid      <= pid_sr_q[3:0];
                rx_addr     <= body_sr_q[6:0];
                rx_endp     <= body_sr_q[10:7];
              end else begin
                token_error <= 1'b1;
              end
              state_q <= StIdle;
            end else if (bit_valid) begin
              state_q <= StIgnore;
            end
          end
          StIgnore: begin
            if (eop) begin
              token_error <= 1'b1;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_token_decoder.sv
// Randomized bench for usb_token_decoder. Each packet outcome comes from a packet-level model:
// a token is good only if it has 24 bits, a valid token PID and a CRC field that matches addr/endp.
module tb_usb_token_decoder;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sync_detected, bit_valid, d_bit, eop;
  logic [3:0] rx_pid;
  logic [6:0] rx_addr;
  logic [3:0] rx_endp;
  logic       token_valid, token_error, busy;

  int checks = 0;
  int errors = 0;
  int tv_cnt = 0, te_cnt = 0, both_cnt = 0;

  logic [3:0] exp_pid;
  logic [6:0] exp_addr;
  logic [3:0] exp_endp;

  usb_token_decoder dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sync_detected (sync_detected),
    .bit_valid     (bit_valid),
    .d_bit         (d_bit),
    .eop           (eop),
    .rx_pid        (rx_pid),
    .rx_addr       (rx_addr),
    .rx_endp       (rx_endp),
    .token_valid   (token_valid),
    .token_error   (token_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Count output pulses just after each active edge.
  always @(posedge clk) begin
    #2;
    if (token_valid) tv_cnt++;
    if (token_error) te_cnt++;
    if (token_valid && token_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at the negedge and are cleared one cycle later.
  task automatic tick(input logic s, input logic bv, input logic d, input logic e);
    sync_detected = s;
    bit_valid     = bv;
    d_bit         = d;
    eop           = e;
    @(negedge clk);
    sync_detected = 1'b0;
    bit_valid     = 1'b0;
    d_bit         = 1'b0;
    eop           = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, s[i], 1'b0);
    end
  endtask

  // USB CRC5 over addr/endp. The result is inverted and returned in wire order, MSB of the CRC first.
  function automatic logic [4:0] crc_field(input logic [10:0] data);
    logic [4:0] c;
    logic [4:0] f;
    c = 5'h1f;
    for (int i = 0; i < 11; i++)
      c = (c[4] ^ data[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
    c = ~c;
    for (int k = 0; k < 5; k++) f[k] = c[4-k];
    return f;
  endfunction

  // Stream layout in wire order: [7:0] pid, [14:8] addr, [18:15] endp, [23:19] crc field.
  function automatic logic [31:0] make_token(input logic [7:0] pid, input logic [6:0] addr,
                                             input logic [3:0] endp);
    return {8'd0, crc_field({endp, addr}), endp, addr, pid};
  endfunction

  function automatic logic pkt_good(input logic [31:0] s, input int n);
    logic [7:0] pid;
    pid = s[7:0];
    if (n != 24) return 1'b0;
    if (pid[7:4] != ~pid[3:0]) return 1'b0;
    if (!(pid[3:0] == 4'h1 || pid[3:0] == 4'h9 || pid[3:0] == 4'hD)) return 1'b0;
    return s[23:19] == crc_field(s[18:8]);
  endfunction

  task automatic run_packet(input string tag, input logic [31:0] s, input int n,
                            input logic eop_bit);
    int   tv0, te0;
    logic good;
    tv0  = tv_cnt;
    te0  = te_cnt;
    good = pkt_good(s, n);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(s, n);
    check({tag, "_busy_pre_eop"}, busy, 1'b1);
    tick(1'b0, eop_bit, 1'($urandom_range(0, 1)), 1'b1);
    if (good) begin
      exp_pid  = s[3:0];
      exp_addr = s[14:8];
      exp_endp = s[18:15];
    end
    check({tag, "_tv"}, token_valid, good);
    check({tag, "_busy_post"}, busy, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_tv_count"}, tv_cnt - tv0, good ? 1 : 0);
    check({tag, "_te_count"}, te_cnt - te0, good ? 0 : 1);
    check({tag, "_rx"}, {rx_pid, rx_addr, rx_endp}, {exp_pid, exp_addr, exp_endp});
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] s2;
    logic [7:0]  tok_pids [3];
    int          tv0, te0, n, kind;
    logic        eb;
    tok_pids[0] = 8'hE1;
    tok_pids[1] = 8'h69;
    tok_pids[2] = 8'h2D;

    n_rst = 1'b0;
    sync_detected = 1'b0; bit_valid = 1'b0; d_bit = 1'b0; eop = 1'b0;
    exp_pid = 4'd0; exp_addr = 7'd0; exp_endp = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_rx", {rx_pid, rx_addr, rx_endp}, 15'd0);
    check("reset_pulses", {token_valid, token_error}, 2'b00);
    check("reset_busy", busy, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // OUT, addr 0x15, endp 0xE; crc_field yields the CRC5 USB writes as 5'h17.
    s = make_token(8'hE1, 7'h15, 4'hE);
    run_packet("good_out", s, 24, 1'b0);
    check("good_out_vals", {rx_pid, rx_addr, rx_endp}, {4'h1, 7'h15, 4'hE});

    run_packet("addr_flip", s ^ 32'h0000_0100, 24, 1'b0);
    check("addr_flip_hold", {rx_pid, rx_addr, rx_endp}, {4'h1, 7'h15, 4'hE});

    s2 = make_token(8'hC3, 7'h2A, 4'h3);
    run_packet("data0", s2, 24, 1'b0);

    run_packet("short", make_token(8'h69, 7'h33, 4'h5), 18, 1'b0);

    // Reset in the middle of a packet; its remaining bits and eop must be ignored.
    s  = make_token(8'h2D, 7'h41, 4'h7);
    tv0 = tv_cnt; te0 = te_cnt;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(s, 12);
    n_rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rx", {rx_pid, rx_addr, rx_endp}, 15'd0);
    exp_pid = 4'd0; exp_addr = 7'd0; exp_endp = 4'd0;
    @(negedge clk);
    n_rst = 1'b1;
    send_bits(s >> 12, 12);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_no_pulse", (tv_cnt - tv0) + (te_cnt - te0), 0);
    run_packet("after_rst", s, 24, 1'b0);

    // Resync mid-body: the abandoned packet must not produce any pulse.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(make_token(8'hE1, 7'h7F, 4'h0), 13);
    run_packet("resync", make_token(8'h69, 7'h0C, 4'h9), 24, 1'b0);

    for (int it = 0; it < 60; it++) begin
      s    = make_token(tok_pids[$urandom_range(0, 2)], 7'($urandom), 4'($urandom));
      n    = 24;
      eb   = 1'b0;
      kind = $urandom_range(0, 5);
      case (kind)
        1: s = s ^ (32'd1 << (8 + $urandom_range(0, 15)));
        2: s[7:0] = 8'($urandom);
        3: n = $urandom_range(0, 23);
        4: begin n = 25; s[24] = 1'($urandom); end
        5: eb = 1'b1;
        default: ;
      endcase
      run_packet($sformatf("rand%0d_k%0d", it, kind), s, n, eb);
    end

    check("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_token_decoder.md
USB_TOKEN_DECODER -- requirements
Module: usb_token_decoder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and n_rst.
REQ-002 The block SHALL have port clk  in  1  system clock; all state changes on posedge.
REQ-003 The block SHALL have port n_rst  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have port sync_detected  in  1  one-cycle strobe: SYNC pattern seen, packet body follows.
REQ-005 The block SHALL have port bit_valid  in  1  one-cycle strobe: d_bit holds one NRZI-decoded, unstuffed bit.
REQ-006 The block SHALL have port d_bit  in  1  received bit, LSB-first per USB field order.
REQ-007 The block SHALL have port eop  in  1  one-cycle strobe: end-of-packet detected.
REQ-008 The block SHALL have port rx_pid  out  4  PID of last good token.
REQ-009 The block SHALL have port rx_addr  out  7  address of last good token.
REQ-010 The block SHALL have port rx_endp  out  4  endpoint of last good token.
REQ-011 The block SHALL have port token_valid  out  1  one-cycle pulse: good token received.
REQ-012 The block SHALL have port token_error  out  1  one-cycle pulse: malformed, non-token or CRC-failed packet.
REQ-013 The block SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, RX_PID, RX_BODY, WAIT_EOP, IGNORE.
REQ-015 IDLE -> RX_PID on sync_detected; bit counter cleared; CRC register preset to 5'b11111.
REQ-016 RX_PID SHALL shift 8 bits into a PID shift register, LSB first.
REQ-017 On the 8th bit, the PID SHALL be checked: pid[7:4] == ~pid[3:0] and pid[3:0] in {4'b0001 OUT, 4'b1001 IN, 4'b1101 SETUP}; pass -> RX_BODY, fail -> IGNORE.
REQ-018 RX_BODY SHALL shift 16 bits: 7 addr, then 4 endp, then 5 CRC, all LSB first.
REQ-019 Every RX_BODY bit SHALL update the CRC: fb = crc[4] ^ d_bit; crc = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b00000).
REQ-020 After the 16th body bit the FSM SHALL go to WAIT_EOP.
REQ-021 In WAIT_EOP, on eop: if crc == 5'b01100 (residual), token_valid SHALL pulse and rx_pid/rx_addr/rx_endp SHALL load, else token_error SHALL pulse; FSM -> IDLE.
REQ-022 A bit_valid in WAIT_EOP (over-length packet) SHALL move the FSM to IGNORE.
REQ-023 eop in RX_PID or RX_BODY (short packet) SHALL pulse token_error; FSM -> IDLE.
REQ-024 IGNORE SHALL discard bits; on eop, token_error SHALL pulse; FSM -> IDLE.
REQ-025 token_valid/token_error SHALL be registered, asserted the cycle after the eop cycle, and never both high.
REQ-026 When bit_valid and eop are both high in one cycle, eop SHALL win and the bit SHALL be discarded.
REQ-027 sync_detected in any non-IDLE state SHALL abort the packet silently (no pulse) and restart at RX_PID.
REQ-028 rx_pid/rx_addr/rx_endp SHALL change only with token_valid and hold otherwise.
REQ-029 Cycles with no strobe SHALL leave all state unchanged.

Reset
REQ-030 On n_rst low, the FSM SHALL go to IDLE, the CRC register to 5'b11111, the counters and shift registers to 0, and all outputs to 0, asynchronously.
REQ-031 Deassertion mid-packet SHALL leave the FSM in IDLE; remaining bits SHALL be ignored until the next sync_detected.

Verification
REQ-032 The bench SHALL cover: sync, PID 8'hE1 (OUT), addr 7'h15, endp 4'hE, CRC field 5'h17, eop -> token_valid one pulse; rx_pid=4'h1, rx_addr=7'h15, rx_endp=4'hE.
REQ-033 The bench SHALL cover: same packet with addr bit 0 flipped -> token_error pulse; rx_* unchanged.
REQ-034 The bench SHALL cover: PID 8'hC3 (DATA0) followed by 16 bits, eop -> token_error; busy high until eop.
REQ-035 The bench SHALL cover: good PID plus 10 body bits, then eop -> token_error; FSM IDLE the next cycle.
REQ-036 The bench SHALL cover: n_rst pulsed after 12 bits, then a full good packet -> exactly one token_valid, from the second packet only.
REQ-037 The bench SHALL cover: sync_detected re-asserted mid-body, then a full good packet -> no error pulse and one token_valid.
